// File: rtl/velocity_display_sequencer_if.sv
// Bus between car physics / bar renderer and the velocity display sequencer.
// The sequencer attaches through the slave modport; whoever drives the frame
// pulse and velocities and consumes the digits uses the master modport.
interface velocity_display_sequencer_if #(
   parameter int VEL_WIDTH = 10
);
   logic                 i_frame_start;
   logic [VEL_WIDTH-1:0] i_car1_vel;
   logic [VEL_WIDTH-1:0] i_car2_vel;
   logic [11:0]          o_car1_digits;
   logic [11:0]          o_car2_digits;
   logic [1:0]           o_car1_blank;
   logic [1:0]           o_car2_blank;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_overrun;

   modport master (
      output i_frame_start, i_car1_vel, i_car2_vel,
      input  o_car1_digits, o_car2_digits, o_car1_blank, o_car2_blank,
             o_busy, o_done, o_overrun
   );

   modport slave (
      input  i_frame_start, i_car1_vel, i_car2_vel,
      output o_car1_digits, o_car2_digits, o_car1_blank, o_car2_blank,
             o_busy, o_done, o_overrun
   );
endinterface

// File: rtl/velocity_display_sequencer.sv
// Per-frame scheduler sharing one sequential double-dabble binary-to-BCD
// converter between car 1 and car 2. Each car's speed magnitude is saturated
// to DISPLAY_MAX and turned into hundred/ten/one digits plus leading-zero
// blank flags for the bar-digit renderer.
module velocity_display_sequencer #(
   parameter int VEL_WIDTH   = 10,
   parameter int DISPLAY_MAX = 999
) (
   input logic                          i_clk,
   input logic                          i_rst_n,
   velocity_display_sequencer_if.slave  bus
);

   // The saturated magnitude never exceeds 2^(VEL_WIDTH-1) nor DISPLAY_MAX,
   // so VEL_WIDTH shift steps always cover it.
   localparam int                 CNT_W    = $clog2(VEL_WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(VEL_WIDTH - 1);
   localparam logic [VEL_WIDTH-1:0] SAT_VAL = VEL_WIDTH'(DISPLAY_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_sel;        // 0 = car 1, 1 = car 2
   logic [VEL_WIDTH-1:0]   r_snap1;
   logic [VEL_WIDTH-1:0]   r_snap2;
   logic [VEL_WIDTH-1:0]   r_bin;
   logic [11:0]            r_bcd;
   logic [CNT_W-1:0]       r_cnt;
   logic [11:0]            r_digits1;
   logic [11:0]            r_digits2;
   logic [1:0]             r_blank1;
   logic [1:0]             r_blank2;
   logic                   r_overrun;

   logic [VEL_WIDTH-1:0]   w_snap_sel;
   logic [VEL_WIDTH:0]     w_ext;
   logic [VEL_WIDTH:0]     w_mag;
   logic [VEL_WIDTH-1:0]   w_sat;
   logic [11:0]            w_bcd_adj;
   logic [12+VEL_WIDTH-1:0] w_dd_next;
   logic [1:0]             w_blank;

   // Magnitude is formed one bit wider so the most negative input does not wrap.
   assign w_snap_sel = r_sel ? r_snap2 : r_snap1;
   assign w_ext      = {w_snap_sel[VEL_WIDTH-1], w_snap_sel};
   assign w_mag      = w_ext[VEL_WIDTH] ? (~w_ext + 1'b1) : w_ext;
   assign w_sat      = (32'(w_mag) > 32'(DISPLAY_MAX)) ? SAT_VAL : w_mag[VEL_WIDTH-1:0];

   // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                       (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
      end
   endgenerate

   assign w_dd_next = {w_bcd_adj, r_bin} << 1;

   // Hundreds blank when zero; tens blank only when hundreds is blank too.
   assign w_blank = {(r_bcd[11:8] == 4'd0), (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0)};

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic for the two-car conversion sequence.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.i_frame_start) w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_SHIFT;
         S_SHIFT: if (r_cnt == LAST_CNT) w_state_next = S_STORE;
         S_STORE: w_state_next = r_sel ? S_DONE : S_LOAD;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: snapshot, converter registers and the held per-car outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sel     <= 1'b0;
         r_snap1   <= '0;
         r_snap2   <= '0;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_digits1 <= 12'h000;
         r_digits2 <= 12'h000;
         r_blank1  <= 2'b11;
         r_blank2  <= 2'b11;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.i_frame_start) begin
                  r_snap1 <= bus.i_car1_vel;
                  r_snap2 <= bus.i_car2_vel;
                  r_sel   <= 1'b0;
               end
            end
            S_LOAD: begin
               r_bin <= w_sat;
               r_bcd <= '0;
               r_cnt <= '0;
            end
            S_SHIFT: begin
               r_bcd <= w_dd_next[VEL_WIDTH +: 12];
               r_bin <= w_dd_next[VEL_WIDTH-1:0];
               r_cnt <= r_cnt + 1'b1;
            end
            S_STORE: begin
               if (r_sel) begin
                  r_digits2 <= r_bcd;
                  r_blank2  <= w_blank;
               end else begin
                  r_digits1 <= r_bcd;
                  r_blank1  <= w_blank;
                  r_sel     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A frame pulse arriving while a sequence runs is dropped and flagged.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_overrun <= 1'b0;
      else          r_overrun <= bus.i_frame_start && (r_state != S_IDLE);
   end

   assign bus.o_car1_digits = r_digits1;
   assign bus.o_car2_digits = r_digits2;
   assign bus.o_car1_blank  = r_blank1;
   assign bus.o_car2_blank  = r_blank2;
   assign bus.o_busy        = (r_state != S_IDLE);
   assign bus.o_done        = (r_state == S_DONE);
   assign bus.o_overrun     = r_overrun;

endmodule

// File: tb/tb_velocity_display_sequencer.sv
// Testbench for velocity_display_sequencer: directed scenarios followed by
// random frames, checked against an arithmetic model of the displayed value.
module tb_velocity_display_sequencer;
   localparam int VW = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   done_before;
   logic [VW-1:0] rv1, rv2;

   velocity_display_sequencer_if #(.VEL_WIDTH(VW)) bus();

   velocity_display_sequencer #(
      .VEL_WIDTH   (VW),
      .DISPLAY_MAX (999)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.o_done === 1'b1) done_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {blank[1:0], hundred, ten, one} from plain decimal arithmetic.
   function automatic logic [13:0] model(input logic [VW-1:0] v);
      int m, h, t, o;
      logic [1:0] b;
      m = $signed(v);
      if (m < 0) m = -m;
      if (m > 999) m = 999;
      h = m / 100;
      t = (m / 10) % 10;
      o = m % 10;
      b[1] = (h == 0);
      b[0] = (h == 0) && (t == 0);
      return {b, 4'(h), 4'(t), 4'(o)};
   endfunction

   task automatic check_car(input string tag, input logic [11:0] d, input logic [1:0] b,
                            input logic [VW-1:0] v);
      logic [13:0] e;
      e = model(v);
      chk({tag, "_digits"}, 32'(d), 32'(e[11:0]));
      chk({tag, "_blank"},  32'(b), 32'(e[13:12]));
   endtask

   // Full frame: pulse, wait to just after E24, check done and both cars.
   task automatic run_frame(input string tag, input logic [VW-1:0] v1, input logic [VW-1:0] v2);
      bus.i_car1_vel = v1;
      bus.i_car2_vel = v2;
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      repeat (24) tick();
      chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
      check_car({tag, "_car1"}, bus.o_car1_digits, bus.o_car1_blank, v1);
      check_car({tag, "_car2"}, bus.o_car2_digits, bus.o_car2_blank, v2);
      tick();
      chk({tag, "_done_end"}, 32'(bus.o_done), 32'd0);
      chk({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_frame_start = 1'b0;
      bus.i_car1_vel = '0;
      bus.i_car2_vel = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // 1: reset / idle state
      chk("rst_car1_digits", 32'(bus.o_car1_digits), 32'h000);
      chk("rst_car2_digits", 32'(bus.o_car2_digits), 32'h000);
      chk("rst_car1_blank",  32'(bus.o_car1_blank),  32'b11);
      chk("rst_car2_blank",  32'(bus.o_car2_blank),  32'b11);
      chk("rst_busy",        32'(bus.o_busy),        32'd0);
      chk("rst_done",        32'(bus.o_done),        32'd0);
      chk("rst_overrun",     32'(bus.o_overrun),     32'd0);

      // 2: 192 / -512 with exact update timing
      bus.i_car1_vel = 10'sd192;
      bus.i_car2_vel = -10'sd512;
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      chk("t2_busy_e0", 32'(bus.o_busy), 32'd1);
      repeat (11) tick();
      chk("t2_car1_hold_e11", 32'(bus.o_car1_digits), 32'h000);
      tick();
      chk("t2_car1_digits_e12", 32'(bus.o_car1_digits), 32'h192);
      chk("t2_car1_blank_e12",  32'(bus.o_car1_blank),  32'b00);
      repeat (11) tick();
      chk("t2_car2_hold_e23", 32'(bus.o_car2_digits), 32'h000);
      chk("t2_done_e23",      32'(bus.o_done),        32'd0);
      tick();
      chk("t2_car2_digits_e24", 32'(bus.o_car2_digits), 32'h512);
      chk("t2_car2_blank_e24",  32'(bus.o_car2_blank),  32'b00);
      chk("t2_done_e24",        32'(bus.o_done),        32'd1);
      chk("t2_busy_e24",        32'(bus.o_busy),        32'd1);
      tick();
      chk("t2_done_e25", 32'(bus.o_done), 32'd0);
      chk("t2_busy_e25", 32'(bus.o_busy), 32'd0);

      // 3: leading-zero blanking
      run_frame("t3", 10'sd7, 10'sd45);
      chk("t3_car2_blank_lit", 32'(bus.o_car2_blank), 32'b10);

      // 4: zero and minus one, single done pulse
      done_before = done_seen;
      run_frame("t4", 10'sd0, -10'sd1);
      repeat (3) tick();
      chk("t4_done_once", 32'(done_seen - done_before), 32'd1);

      // 5: input change at E3 and second frame pulse at E5
      bus.i_car1_vel = 10'sd100;
      bus.i_car2_vel = -10'sd300;
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      repeat (3) tick();
      bus.i_car1_vel = 10'sd5;
      bus.i_car2_vel = 10'sd6;
      tick();
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      chk("t5_overrun_e5", 32'(bus.o_overrun), 32'd1);
      tick();
      chk("t5_overrun_e6", 32'(bus.o_overrun), 32'd0);
      repeat (18) tick();
      chk("t5_done_e24", 32'(bus.o_done), 32'd1);
      check_car("t5_car1", bus.o_car1_digits, bus.o_car1_blank, 10'sd100);
      check_car("t5_car2", bus.o_car2_digits, bus.o_car2_blank, -10'sd300);
      tick();
      chk("t5_done_e25", 32'(bus.o_done), 32'd0);

      // 6: reset mid-sequence at E8
      bus.i_car1_vel = 10'sd300;
      bus.i_car2_vel = -10'sd400;
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      chk("t6_car1_digits", 32'(bus.o_car1_digits), 32'h000);
      chk("t6_car1_blank",  32'(bus.o_car1_blank),  32'b11);
      chk("t6_car2_digits", 32'(bus.o_car2_digits), 32'h000);
      chk("t6_car2_blank",  32'(bus.o_car2_blank),  32'b11);
      chk("t6_busy",        32'(bus.o_busy),        32'd0);
      rst_n = 1'b1;
      done_before = done_seen;
      repeat (30) tick();
      chk("t6_no_done", 32'(done_seen - done_before), 32'd0);
      chk("t6_busy_idle", 32'(bus.o_busy), 32'd0);
      run_frame("t6_after", 10'sd300, -10'sd400);

      // Boundary extremes
      run_frame("edge", 10'sd511, -10'sd511);

      // Random frames against the model
      for (int i = 0; i < 20; i++) begin
         rv1 = VW'($urandom);
         rv2 = VW'($urandom);
         run_frame($sformatf("rnd%0d", i), rv1, rv2);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
